// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready requesters.
// Grants for bursts of up to BURST_MAX words; fifo_full stalls the owner combinationally.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_MAX  = 4
) (
  input  logic                          wr_clk_i,
  input  logic                          rst_n_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic                          fifo_full_i,
  input  logic                          fifo_almost_full_i,
  output logic                          fifo_wr_en_o,
  output logic [DATA_WIDTH-1:0]         fifo_din_o,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          busy_o,
  output logic [15:0]                   stall_cnt_o
);

  localparam int PW  = $clog2(NUM_REQ);
  localparam int BCW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  state_e               state_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic [PW-1:0]        rr_ptr_q;
  logic [BCW-1:0]       beat_cnt_q;
  logic [15:0]          stall_cnt_q;

  logic                 own_vld;
  logic                 own_last;
  logic [DATA_WIDTH-1:0] own_dat;
  logic                 xfer;
  logic                 burst_end;
  logic                 pick_vld;
  logic [PW-1:0]        pick_idx;

  // While in BURST, rr_ptr_q holds the owner's index.
  always_comb begin
    own_vld  = 1'b0;
    own_last = 1'b0;
    own_dat  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (PW'(i) == rr_ptr_q) begin
        own_vld  = req_valid_i[i];
        own_last = req_last_i[i];
        own_dat  = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign xfer      = (state_q == BURST) && own_vld && !fifo_full_i;
  assign burst_end = own_last || (beat_cnt_q == BCW'(BURST_MAX - 1));

  always_comb begin
    req_ready_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (PW'(i) == rr_ptr_q) req_ready_o[i] = xfer;
    end
  end

  assign fifo_wr_en_o = xfer;
  assign fifo_din_o   = xfer ? own_dat : '0;

  // Descending scan so the smallest offset from rr_ptr_q+1 wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if ((i == (int'(rr_ptr_q) + k) % NUM_REQ) && req_valid_i[i]) begin
          pick_vld = 1'b1;
          pick_idx = PW'(i);
        end
      end
    end
  end

  always_ff @(posedge wr_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= PW'(NUM_REQ - 1);
      beat_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld && !fifo_full_i && !fifo_almost_full_i) begin
            grant_q    <= NUM_REQ'(1) << pick_idx;
            rr_ptr_q   <= pick_idx;
            beat_cnt_q <= '0;
            state_q    <= BURST;
          end
        end
        BURST: begin
          if (!own_vld) begin
            grant_q <= '0;
            state_q <= IDLE;
          end else if (fifo_full_i) begin
            if (stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
          end else if (burst_end) begin
            grant_q <= '0;
            state_q <= IDLE;
          end else begin
            beat_cnt_q <= beat_cnt_q + BCW'(1);
          end
        end
        default: begin
          grant_q <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign grant_o     = grant_q;
  assign busy_o      = (state_q == BURST);
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with hand-computed expectations per scenario.
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_af;
  logic        fifo_wr_en;
  logic [7:0]  fifo_din;
  logic [3:0]  grant;
  logic        busy;
  logic [15:0] stall_cnt;

  int vectors;
  int miscompares;

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .BURST_MAX(4)) dut (
    .wr_clk_i           (clk),
    .rst_n_i            (rst_n),
    .req_valid_i        (req_valid),
    .req_data_i         (req_data),
    .req_last_i         (req_last),
    .req_ready_o        (req_ready),
    .fifo_full_i        (fifo_full),
    .fifo_almost_full_i (fifo_af),
    .fifo_wr_en_o       (fifo_wr_en),
    .fifo_din_o         (fifo_din),
    .grant_o            (grant),
    .busy_o             (busy),
    .stall_cnt_o        (stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Inputs change on negedge; checks happen 1 time unit later.
  task automatic apply_reset;
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    fifo_full = 1'b0;
    fifo_af   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    apply_reset();
    #1;
    vectors++;
    if ({grant, busy, fifo_wr_en, req_ready, fifo_din} !== 19'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h expected 0", {grant, busy, fifo_wr_en, req_ready, fifo_din});
    end
    vectors++;
    if (stall_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_stall: got %0d expected 0", stall_cnt);
    end
    vectors++;
    if (dut.rr_ptr_q !== 2'd3) begin
      miscompares++;
      $display("FAIL reset_rr_ptr: got %0d expected 3", dut.rr_ptr_q);
    end
  endtask

  task automatic test_round_robin;
    int         g;
    logic       exp_we;
    logic [3:0] exp_g;
    logic [7:0] exp_d;
    apply_reset();
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = 8'hC0 + 8'(i);
    for (int c = 0; c < 25; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      g = (c / 5) % 4;
      if (c % 5 == 0) begin
        exp_we = 1'b0; exp_g = 4'b0000; exp_d = 8'h00;
      end else begin
        exp_we = 1'b1; exp_g = 4'b0001 << g; exp_d = 8'hC0 + 8'(g);
      end
      vectors++;
      if ({grant, req_ready, fifo_wr_en, fifo_din} !== {exp_g, exp_g, exp_we, exp_d}) begin
        miscompares++;
        $display("FAIL rr_cycle%0d: got grant=%b ready=%b we=%b din=%h expected grant=%b ready=%b we=%b din=%h",
                 c, grant, req_ready, fifo_wr_en, fifo_din, exp_g, exp_g, exp_we, exp_d);
      end
    end
  endtask

  task automatic test_last;
    int writes;
    writes = 0;
    apply_reset();
    req_valid = 4'b0100;
    req_data[23:16] = 8'hA1;
    #1;
    vectors++;
    if (grant !== 4'b0000) begin
      miscompares++;
      $display("FAIL last_idle: got grant=%b expected 0000", grant);
    end
    @(negedge clk); #1;
    writes += int'(fifo_wr_en);
    vectors++;
    if ({grant, req_ready, fifo_wr_en, fifo_din} !== {4'b0100, 4'b0100, 1'b1, 8'hA1}) begin
      miscompares++;
      $display("FAIL last_word1: got grant=%b ready=%b we=%b din=%h expected 0100 0100 1 a1",
               grant, req_ready, fifo_wr_en, fifo_din);
    end
    @(negedge clk);
    req_data[23:16] = 8'hA2;
    req_last = 4'b0100;
    #1;
    writes += int'(fifo_wr_en);
    vectors++;
    if ({fifo_wr_en, fifo_din} !== {1'b1, 8'hA2}) begin
      miscompares++;
      $display("FAIL last_word2: got we=%b din=%h expected 1 a2", fifo_wr_en, fifo_din);
    end
    @(negedge clk);
    req_valid = '0;
    req_last  = '0;
    #1;
    writes += int'(fifo_wr_en);
    vectors++;
    if ({grant, busy, fifo_wr_en} !== 6'd0) begin
      miscompares++;
      $display("FAIL last_exit: got grant=%b busy=%b we=%b expected 0000 0 0", grant, busy, fifo_wr_en);
    end
    vectors++;
    if (dut.rr_ptr_q !== 2'd2) begin
      miscompares++;
      $display("FAIL last_rr_ptr: got %0d expected 2", dut.rr_ptr_q);
    end
    @(negedge clk); #1;
    writes += int'(fifo_wr_en);
    vectors++;
    if (writes !== 2) begin
      miscompares++;
      $display("FAIL last_write_count: got %0d expected 2", writes);
    end
  endtask

  task automatic test_full_stall;
    apply_reset();
    req_valid = 4'b0010;
    req_data[15:8] = 8'h5B;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      fifo_full = 1'b1;
      #1;
      vectors++;
      if ({grant, busy, fifo_wr_en, req_ready} !== {4'b0010, 1'b1, 1'b0, 4'b0000}) begin
        miscompares++;
        $display("FAIL stall_cycle%0d: got grant=%b busy=%b we=%b ready=%b expected 0010 1 0 0000",
                 k, grant, busy, fifo_wr_en, req_ready);
      end
    end
    @(negedge clk);
    fifo_full = 1'b0;
    #1;
    vectors++;
    if (stall_cnt !== 16'd5) begin
      miscompares++;
      $display("FAIL stall_count: got %0d expected 5", stall_cnt);
    end
    vectors++;
    if ({fifo_wr_en, req_ready, fifo_din} !== {1'b1, 4'b0010, 8'h5B}) begin
      miscompares++;
      $display("FAIL stall_release_write: got we=%b ready=%b din=%h expected 1 0010 5b",
               fifo_wr_en, req_ready, fifo_din);
    end
  endtask

  task automatic test_almost_full;
    apply_reset();
    req_valid = 4'b0001;
    req_last  = 4'b0001;
    req_data[7:0] = 8'h11;
    @(negedge clk);
    @(negedge clk);
    req_valid = 4'b1001;
    req_last  = 4'b0000;
    fifo_af   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      vectors++;
      if ({grant, busy} !== 5'd0) begin
        miscompares++;
        $display("FAIL af_hold%0d: got grant=%b busy=%b expected 0000 0", k, grant, busy);
      end
    end
    vectors++;
    if (dut.rr_ptr_q !== 2'd0) begin
      miscompares++;
      $display("FAIL af_rr_ptr: got %0d expected 0", dut.rr_ptr_q);
    end
    @(negedge clk);
    fifo_af = 1'b0;
    @(negedge clk); #1;
    vectors++;
    if (grant !== 4'b1000) begin
      miscompares++;
      $display("FAIL af_next_grant: got %b expected 1000", grant);
    end
  endtask

  task automatic test_abandon;
    apply_reset();
    req_valid = 4'b0011;
    req_data[7:0]  = 8'h30;
    req_data[15:8] = 8'h31;
    @(negedge clk);
    @(negedge clk); #1;
    vectors++;
    if ({grant, fifo_wr_en, fifo_din} !== {4'b0001, 1'b1, 8'h30}) begin
      miscompares++;
      $display("FAIL abandon_beat1: got grant=%b we=%b din=%h expected 0001 1 30", grant, fifo_wr_en, fifo_din);
    end
    @(negedge clk);
    req_valid = 4'b0010;
    #1;
    vectors++;
    if ({grant, busy, fifo_wr_en} !== {4'b0001, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL abandon_drop: got grant=%b busy=%b we=%b expected 0001 1 0", grant, busy, fifo_wr_en);
    end
    @(negedge clk); #1;
    vectors++;
    if ({grant, busy} !== 5'd0) begin
      miscompares++;
      $display("FAIL abandon_idle: got grant=%b busy=%b expected 0000 0", grant, busy);
    end
    @(negedge clk); #1;
    vectors++;
    if ({grant, fifo_wr_en, fifo_din} !== {4'b0010, 1'b1, 8'h31}) begin
      miscompares++;
      $display("FAIL abandon_next: got grant=%b we=%b din=%h expected 0010 1 31", grant, fifo_wr_en, fifo_din);
    end
  endtask

  task automatic test_reset_mid_burst;
    apply_reset();
    req_valid = 4'b1111;
    @(negedge clk);
    fifo_full = 1'b1;
    @(negedge clk);
    fifo_full = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    vectors++;
    if ({grant, busy, fifo_wr_en, stall_cnt} !== {4'b0001, 1'b1, 1'b1, 16'd1}) begin
      miscompares++;
      $display("FAIL midrst_before: got grant=%b busy=%b we=%b stall=%0d expected 0001 1 1 1",
               grant, busy, fifo_wr_en, stall_cnt);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({grant, busy, fifo_wr_en, req_ready, stall_cnt} !== 26'd0) begin
      miscompares++;
      $display("FAIL midrst_clear: got grant=%b busy=%b we=%b ready=%b stall=%0d expected all 0",
               grant, busy, fifo_wr_en, req_ready, stall_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    vectors++;
    if (grant !== 4'b0001) begin
      miscompares++;
      $display("FAIL midrst_regrant: got %b expected 0001", grant);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    req_valid   = '0;
    req_data    = '0;
    req_last    = '0;
    fifo_full   = 1'b0;
    fifo_af     = 1'b0;
    test_reset();
    test_round_robin();
    test_last();
    test_full_stall();
    test_almost_full();
    test_abandon();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
